// File: rtl/dc_sweep_ctrl_pkg.sv
// Shared types and default sizing for the DC bias sweep controller.
package dc_sweep_ctrl_pkg;

  localparam int DEF_DAC_W      = 12;
  localparam int DEF_ADC_W      = 12;
  localparam int DEF_SETTLE_CYC = 64;
  localparam int DEF_AVG_LOG2   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_REQ,
    ST_EMIT,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/sweep_point_acc.sv
// Per-point settle/sample counter and probe-sample accumulator.
module sweep_point_acc
  import dc_sweep_ctrl_pkg::*;
#(
  parameter int ADC_W      = DEF_ADC_W,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      cnt_clr_i,
  input  logic                      cnt_en_i,
  input  logic                      acc_en_i,
  input  logic [ADC_W-1:0]          data_i,
  output logic                      settle_done_o,
  output logic                      samp_done_o,
  output logic [ADC_W+AVG_LOG2-1:0] sum_o
);

  localparam int NSAMP   = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CYC > NSAMP) ? SETTLE_CYC : NSAMP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SUM_W   = ADC_W + AVG_LOG2;

  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] sum_q;

  // One counter serves both phases: settle cycles, then accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (clear_i || cnt_clr_i) cnt_q <= '0;
      else if (cnt_en_i)        cnt_q <= cnt_q + CNT_W'(1);

      if (clear_i)       sum_q <= '0;
      else if (acc_en_i) sum_q <= sum_q + SUM_W'(data_i);
    end
  end

  assign settle_done_o = (cnt_q == CNT_W'(SETTLE_CYC - 1));
  assign samp_done_o   = (cnt_q == CNT_W'(NSAMP - 1));
  assign sum_o         = sum_q;

endmodule

// File: rtl/dc_sweep_ctrl.sv
// Steps a bias DAC across a range, settles, averages probe ADC samples and emits one result per point.
module dc_sweep_ctrl
  import dc_sweep_ctrl_pkg::*;
#(
  parameter int DAC_W      = DEF_DAC_W,
  parameter int ADC_W      = DEF_ADC_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DAC_W-1:0] cfg_start,
  input  logic [DAC_W-1:0] cfg_stop,
  input  logic [DAC_W-1:0] cfg_step,
  output logic [DAC_W-1:0] dac_code,
  output logic             dac_load,
  output logic             adc_req,
  input  logic             adc_ack,
  input  logic [ADC_W-1:0] adc_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DAC_W-1:0] res_code,
  output logic [ADC_W-1:0] res_avg,
  output logic             busy,
  output logic             done
);

  state_e                    state_q;
  logic [DAC_W-1:0]          cfg_stop_q, cfg_step_q, dac_code_q, res_code_q;
  logic [ADC_W-1:0]          res_avg_q;
  logic                      dac_load_q, adc_req_q, res_valid_q, busy_q, done_q;
  logic [DAC_W:0]            next_sum;
  logic                      ack_take, settle_done, samp_done;
  logic [ADC_W+AVG_LOG2-1:0] acc_sum;

  // Acks are only meaningful while a request is outstanding.
  assign ack_take = (state_q == ST_REQ) && adc_req_q && adc_ack;
  assign next_sum = {1'b0, dac_code_q} + {1'b0, cfg_step_q};

  sweep_point_acc #(
    .ADC_W      (ADC_W),
    .AVG_LOG2   (AVG_LOG2),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_acc (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (state_q == ST_LOAD),
    .cnt_clr_i     ((state_q == ST_SETTLE) && settle_done),
    .cnt_en_i      ((state_q == ST_SETTLE) || ack_take),
    .acc_en_i      (ack_take),
    .data_i        (adc_data),
    .settle_done_o (settle_done),
    .samp_done_o   (samp_done),
    .sum_o         (acc_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_stop_q  <= '0;
      cfg_step_q  <= '0;
      dac_code_q  <= '0;
      dac_load_q  <= 1'b0;
      adc_req_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_code_q  <= '0;
      res_avg_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle so they can only ever pulse for one clock.
      dac_load_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        adc_req_q   <= 1'b0;
        res_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: if (start && !abort) begin
            cfg_stop_q <= cfg_stop;
            cfg_step_q <= cfg_step;
            dac_code_q <= cfg_start;
            dac_load_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
          ST_LOAD: state_q <= ST_SETTLE;
          ST_SETTLE: if (settle_done) begin
            adc_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
          ST_REQ: if (ack_take && samp_done) begin
            adc_req_q <= 1'b0;
            state_q   <= ST_EMIT;
          end
          // First EMIT cycle captures the result; the accumulator holds its final value by then.
          ST_EMIT: if (!res_valid_q) begin
            res_valid_q <= 1'b1;
            res_code_q  <= dac_code_q;
            res_avg_q   <= ADC_W'(acc_sum >> AVG_LOG2);
          end else if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_NEXT;
          end
          ST_NEXT: if (next_sum[DAC_W] || (next_sum[DAC_W-1:0] > cfg_stop_q) ||
                       (cfg_step_q == '0)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            dac_code_q <= next_sum[DAC_W-1:0];
            dac_load_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dac_code  = dac_code_q;
  assign dac_load  = dac_load_q;
  assign adc_req   = adc_req_q;
  assign res_valid = res_valid_q;
  assign res_code  = res_code_q;
  assign res_avg   = res_avg_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dc_sweep_ctrl.sv
// Randomized bench for dc_sweep_ctrl with a point-list reference model and a random-latency ADC.
module tb_dc_sweep_ctrl;

  localparam int DAC_W      = 12;
  localparam int ADC_W      = 12;
  localparam int SETTLE_CYC = 64;
  localparam int AVG_LOG2   = 2;
  localparam int NSAMP      = 1 << AVG_LOG2;
  localparam int DAC_MAX    = (1 << DAC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DAC_W-1:0] cfg_start = '0;
  logic [DAC_W-1:0] cfg_stop = '0;
  logic [DAC_W-1:0] cfg_step = '0;
  logic [DAC_W-1:0] dac_code;
  logic             dac_load;
  logic             adc_req;
  logic             adc_ack = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [DAC_W-1:0] res_code;
  logic [ADC_W-1:0] res_avg;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  dc_sweep_ctrl #(
    .DAC_W(DAC_W), .ADC_W(ADC_W), .SETTLE_CYC(SETTLE_CYC), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .dac_code(dac_code), .dac_load(dac_load), .adc_req(adc_req),
    .adc_ack(adc_ack), .adc_data(adc_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_code(res_code), .res_avg(res_avg), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // ADC model: acks a pending request after a random delay and logs every accepted sample.
  bit               fixed_mode  = 1'b1;
  bit               spurious_en = 1'b0;
  int               fix_base    = 0;
  int               ack_cnt     = 0;
  logic [ADC_W-1:0] samp_mem [0:4095];
  logic [ADC_W-1:0] adc_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      adc_ack = 1'b0;
    end else if (adc_req && ($urandom_range(3) != 0)) begin
      adc_d = fixed_mode ? ADC_W'(200 + 2 * ((ack_cnt - fix_base) % 4)) : ADC_W'($urandom);
      adc_ack = 1'b1;
      adc_data = adc_d;
      samp_mem[ack_cnt % 4096] = adc_d;
      ack_cnt++;
    end else if (!adc_req && spurious_en && ($urandom_range(7) == 0)) begin
      adc_ack = 1'b1;
      adc_data = ADC_W'($urandom);
    end else begin
      adc_ack = 1'b0;
    end
  end

  // Protocol observer: tallies events the scenario tasks later inspect.
  int               n_load = 0, n_dbl_load = 0, n_req_rise = 0, n_gap_bad = 0, n_code_nl = 0;
  int               gap = 0;
  logic             prev_load = 1'b0, prev_req = 1'b0;
  logic [DAC_W-1:0] prev_code = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_load = 1'b0;
      prev_req  = 1'b0;
      prev_code = '0;
      gap       = 0;
    end else begin
      if (!dac_load) gap++;
      if (adc_req && !prev_req) begin
        n_req_rise++;
        if (gap != SETTLE_CYC + 1) n_gap_bad++;
      end
      if (dac_load) begin
        n_load++;
        if (prev_load) n_dbl_load++;
        gap = 0;
      end
      if ((dac_code != prev_code) && !dac_load) n_code_nl++;
      prev_load = dac_load;
      prev_req  = adc_req;
      prev_code = dac_code;
    end
  end

  int got_code[$];
  int got_avg[$];

  task automatic run_sweep(input int s, input int e, input int st, input int bp);
    int exp_q[$];
    int code, nxt, rd, idx, cyc, budget, load0, rise0, load_bp, bp_left, sum, exp_avg;
    logic [DAC_W-1:0] hold_code;
    logic [ADC_W-1:0] hold_avg;
    bit seen_done;
    code = s;
    while (1) begin
      exp_q.push_back(code);
      if (st == 0) break;
      nxt = code + st;
      if (nxt > DAC_MAX || nxt > e) break;
      code = nxt;
    end
    got_code.delete();
    got_avg.delete();
    idx = 0; cyc = 0; seen_done = 1'b0; bp_left = bp; load_bp = 0;
    hold_code = '0; hold_avg = '0;
    budget = 300 * exp_q.size() + 300;
    @(negedge clk);
    cfg_start = DAC_W'(s); cfg_stop = DAC_W'(e); cfg_step = DAC_W'(st);
    start = 1'b1;
    fix_base = ack_cnt; rd = ack_cnt; load0 = n_load; rise0 = n_req_rise;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (dac_load !== 1'b1 || dac_code !== DAC_W'(s) || busy !== 1'b1) begin
      errors++;
      $display("FAIL sweep_start: load=%b code=%0d busy=%b, want load=1 code=%0d busy=1",
               dac_load, dac_code, busy, s);
    end
    while (!seen_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      cfg_start = DAC_W'($urandom); cfg_stop = DAC_W'($urandom); cfg_step = DAC_W'($urandom);
      if (done) begin
        seen_done = 1'b1;
        start = 1'b0;
        checks++;
        if (idx != exp_q.size() || busy !== 1'b0) begin
          errors++;
          $display("FAIL sweep_end: results=%0d busy=%b, want results=%0d busy=0",
                   idx, busy, exp_q.size());
        end
      end else begin
        start = ($urandom_range(15) == 0);
        if (res_valid) begin
          if (bp_left > 0) begin
            if (bp_left == bp) begin
              hold_code = res_code; hold_avg = res_avg; load_bp = n_load;
            end else begin
              checks++;
              if (res_code !== hold_code || res_avg !== hold_avg || n_load != load_bp) begin
                errors++;
                $display("FAIL backpressure_hold: code=%0d avg=%0d loads=%0d, want code=%0d avg=%0d loads=%0d",
                         res_code, res_avg, n_load, hold_code, hold_avg, load_bp);
              end
            end
            res_ready = 1'b0;
            bp_left--;
          end else begin
            res_ready = ($urandom_range(1) == 1);
          end
          if (res_ready) begin
            checks++;
            if (idx >= exp_q.size()) begin
              errors++;
              $display("FAIL extra_result: code=%0d, want no more than %0d results",
                       res_code, exp_q.size());
            end else begin
              sum = 0;
              for (int k = 0; k < NSAMP; k++) sum += int'(samp_mem[(rd + k) % 4096]);
              exp_avg = sum >> AVG_LOG2;
              if (res_code !== DAC_W'(exp_q[idx]) || res_avg !== ADC_W'(exp_avg)) begin
                errors++;
                $display("FAIL result_%0d: code=%0d avg=%0d, want code=%0d avg=%0d",
                         idx, res_code, res_avg, exp_q[idx], exp_avg);
              end
            end
            got_code.push_back(int'(res_code));
            got_avg.push_back(int'(res_avg));
            idx++;
            rd += NSAMP;
          end
        end else begin
          res_ready = ($urandom_range(1) == 1);
        end
      end
    end
    start = 1'b0;
    res_ready = 1'b0;
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: no done within %0d cycles", budget);
    end
    checks++;
    if (n_load - load0 != exp_q.size() || n_req_rise - rise0 != exp_q.size()) begin
      errors++;
      $display("FAIL load_req_count: loads=%0d req_rises=%0d, want %0d each",
               n_load - load0, n_req_rise - rise0, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({dac_code, dac_load, adc_req, res_valid, busy, done, res_code, res_avg} !== '0) begin
      errors++;
      $display("FAIL reset_state: code=%0d load=%b req=%b valid=%b busy=%b done=%b rcode=%0d ravg=%0d, want all 0",
               dac_code, dac_load, adc_req, res_valid, busy, done, res_code, res_avg);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dac_load !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b load=%b, want 0 0", busy, dac_load);
    end
  endtask

  task automatic test_basic();
    fixed_mode = 1'b1;
    run_sweep(100, 400, 100, 0);
    checks++;
    if (got_code.size() != 4) begin
      errors++;
      $display("FAIL basic_count: %0d results, want 4", got_code.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_code[i] != 100 * (i + 1) || got_avg[i] != 203) begin
          errors++;
          $display("FAIL basic_point_%0d: (%0d,%0d), want (%0d,203)",
                   i, got_code[i], got_avg[i], 100 * (i + 1));
        end
      end
    end
    checks++;
    if (dac_code !== 12'd400) begin
      errors++;
      $display("FAIL basic_hold_code: dac_code=%0d, want 400", dac_code);
    end
  endtask

  task automatic test_overshoot();
    run_sweep(0, 250, 100, 0);
    checks++;
    if (got_code.size() != 3 || got_code[0] != 0 || got_code[1] != 100 || got_code[2] != 200) begin
      errors++;
      $display("FAIL overshoot_codes: %0d results, want codes 0,100,200", got_code.size());
    end
  endtask

  task automatic test_wrap();
    run_sweep(4000, 4095, 100, 0);
    checks++;
    if (got_code.size() != 1 || got_code[0] != 4000 || dac_code !== 12'd4000) begin
      errors++;
      $display("FAIL wrap_single: %0d results dac_code=%0d, want one result at 4000", got_code.size(), dac_code);
    end
    run_sweep(700, 300, 50, 0);
    checks++;
    if (got_code.size() != 1 || got_code[0] != 700) begin
      errors++;
      $display("FAIL stop_below_start: %0d results, want one at 700", got_code.size());
    end
  endtask

  task automatic test_backpressure();
    fixed_mode = 1'b0;
    run_sweep(1000, 1200, 100, 20);
  endtask

  task automatic test_abort();
    int rise0, cyc;
    bit bad;
    fixed_mode = 1'b1;
    @(negedge clk);
    cfg_start = 12'd100; cfg_stop = 12'd400; cfg_step = 12'd100;
    start = 1'b1; fix_base = ack_cnt;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 500) begin @(negedge clk); cyc++; end
    res_ready = 1'b1;
    checks++;
    if (res_valid !== 1'b1 || res_code !== 12'd100 || res_avg !== 12'd203) begin
      errors++;
      $display("FAIL abort_first_point: valid=%b (%0d,%0d), want 1 (100,203)", res_valid, res_code, res_avg);
    end
    @(negedge clk);
    res_ready = 1'b0;
    cyc = 0;
    while (!dac_load && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (dac_load !== 1'b1 || dac_code !== 12'd200) begin
      errors++;
      $display("FAIL abort_second_load: load=%b code=%0d, want 1 200", dac_load, dac_code);
    end
    rise0 = n_req_rise;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || adc_req !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_response: done=%b busy=%b req=%b valid=%b, want 1 0 0 0", done, busy, adc_req, res_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done_pulse: done=%b, want 0", done);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dac_load !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort: busy=%b load=%b done=%b, want 0 0 0", busy, dac_load, done);
    end
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (res_valid || adc_req || busy) bad = 1'b1;
    end
    checks++;
    if (bad || n_req_rise != rise0) begin
      errors++;
      $display("FAIL abort_quiet: activity=%b req_rises=%0d, want 0 0", bad, n_req_rise - rise0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, s;
    fixed_mode = 1'b1;
    @(negedge clk);
    cfg_start = 12'd500; cfg_stop = 12'd1000; cfg_step = 12'd50;
    start = 1'b1; fix_base = ack_cnt;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!adc_req && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (adc_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_reach_req: adc_req=%b, want 1", adc_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dac_code, dac_load, adc_req, res_valid, busy, done, res_code, res_avg} !== '0) begin
      errors++;
      $display("FAIL reset_async: code=%0d load=%b req=%b valid=%b busy=%b done=%b rcode=%0d ravg=%0d, want all 0",
               dac_code, dac_load, adc_req, res_valid, busy, done, res_code, res_avg);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s = $urandom_range(DAC_MAX);
    fixed_mode = 1'b0;
    run_sweep(s, $urandom_range(DAC_MAX), 0, 0);
    checks++;
    if (got_code.size() != 1 || got_code[0] != s) begin
      errors++;
      $display("FAIL step_zero_single: %0d results, want one at %0d", got_code.size(), s);
    end
  endtask

  task automatic test_random();
    fixed_mode = 1'b0;
    spurious_en = 1'b1;
    for (int i = 0; i < 6; i++)
      run_sweep($urandom_range(DAC_MAX), $urandom_range(DAC_MAX), $urandom_range(1200, 200), 0);
    spurious_en = 1'b0;
  endtask

  task automatic test_protocol();
    checks++;
    if (n_gap_bad != 0 || n_dbl_load != 0 || n_code_nl != 0) begin
      errors++;
      $display("FAIL protocol: bad_settle_gaps=%0d double_loads=%0d silent_code_changes=%0d, want 0 0 0",
               n_gap_bad, n_dbl_load, n_code_nl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overshoot();
    test_wrap();
    test_backpressure();
    test_abort();
    test_reset_mid_sweep();
    test_random();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_sweep_ctrl.md
DC_SWEEP_CTRL -- requirements
Module: dc_sweep_ctrl

Interface
REQ-001 Parameter DAC_W, default 12, bias DAC code width.
REQ-002 Parameter ADC_W, default 12, probe ADC sample width.
REQ-003 Parameter SETTLE_CYC, default 64, clock cycles between a DAC load and the first ADC request.
REQ-004 Parameter AVG_LOG2, default 2, log2 of the number of samples averaged per sweep point.
REQ-005 clk  in  1  sole clock; all logic is on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse that begins a sweep; ignored while busy.
REQ-008 abort  in  1  level input; ends the sweep at the next edge.
REQ-009 cfg_start / cfg_stop / cfg_step  in  DAC_W each  sweep bounds and increment, sampled on an accepted start.
REQ-010 dac_code  out  DAC_W  bias code driven to the Vdc source DAC.
REQ-011 dac_load  out  1  single-cycle strobe whenever dac_code changes.
REQ-012 adc_req  out  1  held high until adc_ack.
REQ-013 adc_ack / adc_data  in  1 / ADC_W  probe sample, valid in the same cycle as adc_ack.
REQ-014 res_valid  out  1; res_ready  in  1  valid/ready result handshake.
REQ-015 res_code / res_avg  out  DAC_W / ADC_W  bias point and its averaged probe reading.
REQ-016 busy  out  1; done  out  1  sweep active; single-cycle completion pulse.

Function
REQ-017 States are IDLE, LOAD, SETTLE, REQ, EMIT and NEXT.
REQ-018 IDLE->LOAD on start; the block latches the cfg values and sets dac_code=cfg_start.
REQ-019 LOAD asserts dac_load for exactly one cycle and then goes to SETTLE.
REQ-020 SETTLE counts SETTLE_CYC cycles, then goes to REQ; adc_req rises exactly SETTLE_CYC+1 cycles after dac_load.
REQ-021 REQ holds adc_req until adc_ack and adds adc_data to an (ADC_W+AVG_LOG2)-bit accumulator.
REQ-022 After 2^AVG_LOG2 acks the block goes to EMIT; adc_req drops in the cycle after the last ack.
REQ-023 An ack that arrives while adc_req is low is ignored.
REQ-024 EMIT sets res_avg = accumulator >> AVG_LOG2 (truncating) and res_code = dac_code.
REQ-025 EMIT holds res_valid with stable data until res_ready; a transfer occurs on valid&&ready.
REQ-026 NEXT computes dac_code+cfg_step at DAC_W+1 bits.
REQ-027 NEXT ends the sweep if the carry is set, the sum exceeds cfg_stop, or cfg_step==0; otherwise it goes to LOAD with the new code and a cleared accumulator.
REQ-028 If cfg_stop<cfg_start, exactly one point (cfg_start) is produced.
REQ-029 A sum equal to cfg_stop is included as a point.
REQ-030 Sweep end: done pulses for one cycle, busy falls, and the state returns to IDLE; dac_code holds its last value.
REQ-031 abort in any non-IDLE state: the block goes to IDLE next cycle, drops adc_req and res_valid, discards the partial point, and pulses done.
REQ-032 A start coincident with abort is ignored.
REQ-033 busy is high in every state except IDLE.

Reset
REQ-034 Asserting rst_n low immediately forces IDLE and sets dac_code=0, with dac_load, adc_req, res_valid, busy and done all 0, res_code=0 and res_avg=0.
REQ-035 Reset mid-sweep discards all progress; the first start after deassertion begins a fresh sweep.

Structure
REQ-036 A shared package holds the state enumeration and default parameter constants.
REQ-037 The settle counter and sample accumulator are one sub-module, sweep_point_acc, with clear, enable, count-done and sum outputs.

Verification
REQ-038 Basic sweep (start=100, stop=400, step=100, ADC returns 200,202,204,206 for each point): four results (100,203), (200,203), (300,203), (400,203), then done.
REQ-039 Overshoot (start=0, stop=250, step=100): results at codes 0, 100 and 200 only.
REQ-040 Wrap (start=4000, stop=4095, step=100): one result at 4000, then done with no wrap to a low code.
REQ-041 Backpressure with res_ready low for 20 cycles: res_valid, res_code and res_avg stay stable, and no new dac_load occurs.
REQ-042 abort during SETTLE of the second point: done in the next cycle, no second result, and adc_req never rises.
REQ-043 rst_n low during REQ: all outputs reset immediately; a later start (step=0) gives a single result at cfg_start.
